// File: rtl/apu_pkg.sv
// Shared APU constants: frame-sequencer step table defaults, mode encoding
// and $4017 register bit positions.
package apu_pkg;

  localparam int Q1_DEFAULT        = 7457;
  localparam int Q2_DEFAULT        = 14913;
  localparam int Q3_DEFAULT        = 22371;
  localparam int Q4_DEFAULT        = 29829;
  localparam int Q5_DEFAULT        = 37281;
  localparam int CNT_WIDTH_DEFAULT = 16;

  localparam logic MODE_4STEP = 1'b0;
  localparam logic MODE_5STEP = 1'b1;

  localparam int MODE_BIT    = 7;
  localparam int INHIBIT_BIT = 6;

endpackage

// File: rtl/frame_sequencer.sv
// APU frame sequencer: quarter/half-frame strobes and the frame IRQ flag.
// Define FRAME_IRQ_EN to build the IRQ flag; otherwise oIrq is tied low.
module frame_sequencer
  import apu_pkg::*;
#(
  parameter int Q1        = Q1_DEFAULT,
  parameter int Q2        = Q2_DEFAULT,
  parameter int Q3        = Q3_DEFAULT,
  parameter int Q4        = Q4_DEFAULT,
  parameter int Q5        = Q5_DEFAULT,
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iCpu_en,
  input  logic       iW,
  input  logic [7:0] iRegister,
  input  logic       iIrq_ack,
  output logic       oLinear_clk,
  output logic       oLength_clk,
  output logic       oIrq,
  output logic       oMode
);

  localparam logic [CNT_WIDTH-1:0] STEP1   = CNT_WIDTH'(Q1);
  localparam logic [CNT_WIDTH-1:0] STEP2   = CNT_WIDTH'(Q2);
  localparam logic [CNT_WIDTH-1:0] STEP3   = CNT_WIDTH'(Q3);
  localparam logic [CNT_WIDTH-1:0] STEP4   = CNT_WIDTH'(Q4);
  localparam logic [CNT_WIDTH-1:0] STEP5   = CNT_WIDTH'(Q5);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, last_s;
  logic                 mode_q, mode_d;
  logic                 lin_q, lin_d;
  logic                 len_q, len_d;
  logic                 tick_s, seq_end_s, quarter_s, half_s;

  assign tick_s = iCpu_en & ~iW;

  // Step decode; >= on the end step keeps cnt bounded even from a corrupt value.
  always_comb begin
    last_s    = (mode_q == MODE_5STEP) ? STEP5 : STEP4;
    seq_end_s = (cnt_q >= last_s);
    half_s    = (cnt_q == STEP2) | seq_end_s;
    quarter_s = (cnt_q == STEP1) | (cnt_q == STEP3) | half_s;
  end

  // Next-state for counter, mode and strobes; a write overrides a coincident tick.
  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    lin_d  = 1'b0;
    len_d  = 1'b0;
    if (iW) begin
      mode_d = iRegister[MODE_BIT];
      cnt_d  = CNT_ZERO;
      lin_d  = iRegister[MODE_BIT];
      len_d  = iRegister[MODE_BIT];
    end else if (iCpu_en) begin
      lin_d = quarter_s;
      len_d = half_s;
      if (seq_end_s) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d  = cnt_q;
      mode_d = mode_q;
    end
  end

  // Sequencer state and registered strobes.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      cnt_q  <= CNT_ZERO;
      mode_q <= MODE_4STEP;
      lin_q  <= 1'b0;
      len_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      lin_q  <= lin_d;
      len_q  <= len_d;
    end
  end

  assign oLinear_clk = lin_q;
  assign oLength_clk = len_q;
  assign oMode       = mode_q;

`ifdef FRAME_IRQ_EN
  logic inhibit_q, inhibit_d;
  logic irq_q, irq_d;
  logic irq_set_s;
  logic unused_s;

  assign irq_set_s = tick_s & (mode_q == MODE_4STEP) & (cnt_q == STEP4) & ~inhibit_q;
  assign unused_s  = ^iRegister[5:0];

  // IRQ priority: inhibit write clears, then set, then acknowledge clears.
  always_comb begin
    inhibit_d = inhibit_q;
    irq_d     = irq_q;
    if (iW) begin
      inhibit_d = iRegister[INHIBIT_BIT];
    end else begin
      inhibit_d = inhibit_q;
    end
    if (iW && iRegister[INHIBIT_BIT]) begin
      irq_d = 1'b0;
    end else if (irq_set_s) begin
      irq_d = 1'b1;
    end else if (iIrq_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // IRQ flag and inhibit registers.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
    end
  end

  assign oIrq = irq_q;
`else
  logic unused_s;
  assign unused_s = ^{iIrq_ack, iRegister[6:0], tick_s};
  assign oIrq     = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer against a step-table reference model.
module tb_frame_sequencer;

  localparam int Q1 = 4;
  localparam int Q2 = 9;
  localparam int Q3 = 14;
  localparam int Q4 = 19;
  localparam int Q5 = 24;
`ifdef FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, w, ack;
  logic [7:0] data;
  logic       lin, len, irq, mode;

  int checks   = 0;
  int failures = 0;

  // reference model state: position within the sequence and programmed fields
  int m_pos;
  bit m_mode, m_inh, m_irq, m_lin, m_len;

  frame_sequencer #(.Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .CNT_WIDTH(16)) dut (
    .iClk        (clk),
    .iReset_n    (rst_n),
    .iCpu_en     (en),
    .iW          (w),
    .iRegister   (data),
    .iIrq_ack    (ack),
    .oLinear_clk (lin),
    .oLength_clk (len),
    .oIrq        (irq),
    .oMode       (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (t=%0t pos=%0d)", tag, obs, exp, $time, m_pos);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_lin = 0; m_len = 0;
  endtask

  // Apply the current inputs to the model as one clock edge.
  task automatic model_step();
    int last;
    bit set;
    m_lin = 0;
    m_len = 0;
    if (w) begin
      m_mode = data[7];
      m_inh  = IRQ_EN ? data[6] : 1'b0;
      m_pos  = 0;
      m_lin  = data[7];
      m_len  = data[7];
      if (IRQ_EN && data[6]) m_irq = 0;
      else if (IRQ_EN && ack) m_irq = 0;
    end else if (en) begin
      last  = m_mode ? Q5 : Q4;
      m_lin = (m_pos == Q1) || (m_pos == Q2) || (m_pos == Q3) || (m_pos == last);
      m_len = (m_pos == Q2) || (m_pos == last);
      set   = IRQ_EN && !m_mode && (m_pos == Q4) && !m_inh;
      m_pos = (m_pos == last) ? 0 : m_pos + 1;
      if (set) m_irq = 1;
      else if (IRQ_EN && ack) m_irq = 0;
    end else begin
      if (IRQ_EN && ack) m_irq = 0;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("linear_clk", lin, m_lin);
    check("length_clk", len, m_len);
    check("irq", irq, m_irq);
    check("mode", mode, m_mode);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Tick until the model sits at position p, bounded.
  task automatic run_until_pos(input int p);
    int k;
    k = 0;
    while (m_pos != p && k < 200) begin
      cycle();
      k++;
    end
    check("reach_pos_bound", (m_pos == p), 1'b1);
  endtask

  task automatic write_reg(input logic [7:0] v);
    w = 1'b1; data = v;
    cycle();
    w = 1'b0; data = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; w = 1'b0; ack = 1'b0; data = 8'h00;
    model_reset();
    #12;
    check("rst_lin", lin, 1'b0);
    check("rst_len", len, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_mode", mode, 1'b0);
    rst_n = 1'b1;

    // 1: 4-step sequence, two full periods
    en = 1'b1;
    write_reg(8'h00);
    run(45);

    // 3: inhibit write clears irq and keeps it clear
    run_until_pos(Q4);
    cycle();
    check("s3_irq_set", irq, IRQ_EN);
    write_reg(8'h40);
    check("s3_irq_clr", irq, 1'b0);
    run(25);
    write_reg(8'h00);
    run_until_pos(Q4);
    cycle();
    en = 1'b0; ack = 1'b1;
    cycle();
    ack = 1'b0; en = 1'b1;
    check("s3_ack_clr", irq, 1'b0);

    // 4: ack coincident with the set tick: set wins
    run_until_pos(Q4);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    check("s4_set_beats_ack", irq, IRQ_EN);

    // 2: 5-step mode with immediate strobe pair
    write_reg(8'h80);
    check("s2_wr_lin", lin, 1'b1);
    check("s2_wr_len", len, 1'b1);
    run(55);

    // 5: sparse ticks, write on a tick edge at pos 8
    write_reg(8'h00);
    begin
      bit done;
      done = 0;
      for (int k = 0; k < 150; k++) begin
        en = (k % 3 == 0);
        if (en && !done && m_pos == 8) begin
          w = 1'b1; data = 8'h00; done = 1;
        end
        cycle();
        w = 1'b0;
      end
      check("s5_write_hit", done, 1'b1);
    end

    // 6: short async reset mid-sequence
    en = 1'b1;
    run_until_pos(12);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("s6_lin", lin, 1'b0);
    check("s6_len", len, 1'b0);
    check("s6_irq", irq, 1'b0);
    check("s6_mode", mode, 1'b0);
    #1 rst_n = 1'b1;
    run(12);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      en   = 1'($urandom_range(0, 1));
      ack  = ($urandom_range(0, 7) == 0);
      w    = ($urandom_range(0, 39) == 0);
      data = 8'($urandom);
      cycle();
    end
    w = 1'b0; ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
